// File: rtl/ul_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// legal quotient-bits-per-cycle values and the iteration-counter width helper.
package ul_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BPC_SINGLE = 1;
  localparam int BPC_DOUBLE = 2;

  function automatic int cnt_width(input int iterations);
    return $clog2(iterations + 1);
  endfunction

endpackage

// File: rtl/ul_div_seq_if.sv
// Request/result bundle of ul_div_seq; the sgn field exists only when
// UL_DIV_SEQ_SIGNED_EN is defined.
interface ul_div_seq_if #(
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 11
);

  logic                      start;
  logic                      abort;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
`ifdef UL_DIV_SEQ_SIGNED_EN
  logic                      sgn;
`endif
  logic                      busy;
  logic                      done;
  logic                      dbz;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;

`ifdef UL_DIV_SEQ_SIGNED_EN
  modport master (output start, abort, dividend, divisor, sgn,
                  input  busy, done, dbz, quotient, remainder);
  modport slave  (input  start, abort, dividend, divisor, sgn,
                  output busy, done, dbz, quotient, remainder);
`else
  modport master (output start, abort, dividend, divisor,
                  input  busy, done, dbz, quotient, remainder);
  modport slave  (input  start, abort, dividend, divisor,
                  output busy, done, dbz, quotient, remainder);
`endif

endinterface

// File: rtl/ul_div_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// subtract the divisor when the padded remainder is large enough.
module ul_div_step #(
  parameter int DIVISOR_WIDTH = 11
) (
  input  logic [DIVISOR_WIDTH-1:0] rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [DIVISOR_WIDTH-1:0] rem_o,
  output logic                     q_o
);

  logic [DIVISOR_WIDTH:0] pad;

  assign pad = {rem_i, bit_i};
  assign q_o = (pad >= {1'b0, divisor_i});
  // When q_o is set the difference is below the divisor, so the low bits hold it exactly
  assign rem_o = q_o ? (pad[DIVISOR_WIDTH-1:0] - divisor_i) : pad[DIVISOR_WIDTH-1:0];

endmodule

// File: rtl/ul_div_seq.sv
// Multi-cycle restoring divider, 1 or 2 quotient bits per clock.
// Define UL_DIV_SEQ_SIGNED_EN for two's-complement operation (adds sgn and a FIXUP state).
module ul_div_seq
  import ul_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 22,
  parameter int DIVISOR_WIDTH  = 11,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic          clk,
  input logic          rst,
  ul_div_seq_if.slave  bus
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N = DW / BPC;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (BPC != BPC_SINGLE && BPC != BPC_DOUBLE) begin : g_bad_bpc
    $error("ul_div_seq: BITS_PER_CYCLE must be 1 or 2");
  end
  if ((DW % BPC) != 0 || DW <= BPC) begin : g_bad_dw
    $error("ul_div_seq: DIVIDEND_WIDTH must be a multiple of BITS_PER_CYCLE");
  end
  if (VW > DW) begin : g_bad_vw
    $error("ul_div_seq: DIVISOR_WIDTH must not exceed DIVIDEND_WIDTH");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [VW-1:0]   dvs_q, dvs_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [VW-1:0]   rmd_q, rmd_d;
  logic            dbz_q, dbz_d;
  logic [DW-1:0]   dvd_mag;
  logic [VW-1:0]   dvs_mag;
`ifdef UL_DIV_SEQ_SIGNED_EN
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
`endif

  // dvd_q shifts left each iteration: dividend bits leave at the top, quotient bits enter at the bottom
  logic [VW-1:0]   rem_chain [BPC+1];
  logic [BPC-1:0]  qbits;

  assign rem_chain[0] = rem_q;

  for (genvar k = 0; k < BPC; k++) begin : g_step
    ul_div_step #(.DIVISOR_WIDTH(VW)) u_step (
      .rem_i     (rem_chain[k]),
      .bit_i     (dvd_q[DW-1-k]),
      .divisor_i (dvs_q),
      .rem_o     (rem_chain[k+1]),
      .q_o       (qbits[BPC-1-k])
    );
  end

`ifdef UL_DIV_SEQ_SIGNED_EN
  assign dvd_mag = (bus.sgn && bus.dividend[DW-1]) ? -bus.dividend : bus.dividend;
  assign dvs_mag = (bus.sgn && bus.divisor[VW-1])  ? -bus.divisor  : bus.divisor;
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
`ifdef UL_DIV_SEQ_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvd_d = dvd_mag;
          dvs_d = dvs_mag;
          rem_d = '0;
          cnt_d = '0;
`ifdef UL_DIV_SEQ_SIGNED_EN
          negq_d = bus.sgn && (bus.dividend[DW-1] ^ bus.divisor[VW-1]);
          negr_d = bus.sgn && bus.dividend[DW-1];
`endif
          if (bus.divisor == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rmd_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_chain[BPC];
          dvd_d = {dvd_q[DW-BPC-1:0], qbits};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
`ifdef UL_DIV_SEQ_SIGNED_EN
            state_d = ST_FIXUP;
`else
            state_d = ST_DONE;
            quo_d   = dvd_d;
            rmd_d   = rem_d;
            dbz_d   = 1'b0;
`endif
          end
        end
      end
`ifdef UL_DIV_SEQ_SIGNED_EN
      ST_FIXUP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          quo_d   = negq_q ? -dvd_q : dvd_q;
          rmd_d   = negr_q ? -rem_q : rem_q;
          dbz_d   = 1'b0;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef UL_DIV_SEQ_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
`ifdef UL_DIV_SEQ_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign bus.busy      = (state_q == ST_CALC) || (state_q == ST_FIXUP);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.dbz       = dbz_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;

endmodule

// File: tb/tb_ul_div_seq.sv
// Directed bench for ul_div_seq: one instance at 1 bit/cycle, one at 2 bits/cycle.
module tb_ul_div_seq;

`ifdef UL_DIV_SEQ_SIGNED_EN
  localparam int FIX = 1;
`else
  localparam int FIX = 0;
`endif
  localparam int LAT_A = 22 + FIX;
  localparam int LAT_B = 11 + FIX;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ul_div_seq_if #(.DIVIDEND_WIDTH(22), .DIVISOR_WIDTH(11)) ia ();
  ul_div_seq_if #(.DIVIDEND_WIDTH(22), .DIVISOR_WIDTH(11)) ib ();

  ul_div_seq #(.DIVIDEND_WIDTH(22), .DIVISOR_WIDTH(11), .BITS_PER_CYCLE(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ia));
  ul_div_seq #(.DIVIDEND_WIDTH(22), .DIVISOR_WIDTH(11), .BITS_PER_CYCLE(2)) dut_b (
    .clk (clk), .rst (rst), .bus (ib));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic ab,
                       input logic [21:0] a, input logic [10:0] b, input logic sg);
    if (w == 0) begin
      ia.start = st; ia.abort = ab; ia.dividend = a; ia.divisor = b;
`ifdef UL_DIV_SEQ_SIGNED_EN
      ia.sgn = sg;
`endif
    end else begin
      ib.start = st; ib.abort = ab; ib.dividend = a; ib.divisor = b;
`ifdef UL_DIV_SEQ_SIGNED_EN
      ib.sgn = sg;
`endif
    end
    if (sg) begin end
  endtask

  function automatic logic rd_done(input int w);  return (w == 0) ? ia.done : ib.done; endfunction
  function automatic logic rd_busy(input int w);  return (w == 0) ? ia.busy : ib.busy; endfunction
  function automatic logic rd_dbz(input int w);   return (w == 0) ? ia.dbz  : ib.dbz;  endfunction
  function automatic logic [21:0] rd_q(input int w); return (w == 0) ? ia.quotient : ib.quotient; endfunction
  function automatic logic [10:0] rd_r(input int w); return (w == 0) ? ia.remainder : ib.remainder; endfunction

  // inject >= 0 pulses a stray start that many cycles into the calculation
  task automatic run(input int w, input logic [21:0] a, input logic [10:0] b, input logic sg,
                     input logic [21:0] eq, input logic [10:0] er, input logic edbz,
                     input int elat, input int inject, input logic ab_start, input string tag);
    int lat;
    int bc;
    @(negedge clk);
    drive(w, 1'b1, ab_start, a, b, sg);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, a, b, sg);
    lat = 0;
    bc  = 0;
    while (!rd_done(w) && lat < 100) begin
      if (rd_busy(w)) bc++;
      if (lat == inject) drive(w, 1'b1, 1'b0, 22'd10, 11'd1, sg);
      @(posedge clk); #1;
      if (lat == inject) drive(w, 1'b0, 1'b0, a, b, sg);
      lat++;
    end
    chk({tag, " done"}, 64'(rd_done(w)), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " busy cycles"}, 64'(bc), 64'(elat));
    chk({tag, " quotient"}, 64'(rd_q(w)), 64'(eq));
    chk({tag, " remainder"}, 64'(rd_r(w)), 64'(er));
    chk({tag, " dbz"}, 64'(rd_dbz(w)), 64'(edbz));
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 64'(rd_done(w)), 64'd0);
    chk({tag, " quotient held"}, 64'(rd_q(w)), 64'(eq));
  endtask

  initial begin
    int seen;
    logic [21:0] ra;
    logic [10:0] rb;
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(ia.busy), 64'd0);
    chk("reset done", 64'(ia.done), 64'd0);
    chk("reset dbz", 64'(ia.dbz), 64'd0);
    chk("reset quotient", 64'(ia.quotient), 64'd0);
    chk("reset remainder", 64'(ib.remainder), 64'd0);
    rst = 1'b0;

    run(0, 22'd1000000, 11'd1000, 1'b0, 22'd1000, 11'd0, 1'b0, LAT_A, -1, 1'b0, "a 1000000/1000");
    run(1, 22'd1023, 11'd7, 1'b0, 22'd146, 11'd1, 1'b0, LAT_B, -1, 1'b0, "b 1023/7");
    run(1, 22'd9, 11'd9, 1'b0, 22'd1, 11'd0, 1'b0, LAT_B, -1, 1'b0, "b 9/9");
    run(1, 22'd5, 11'd9, 1'b0, 22'd0, 11'd5, 1'b0, LAT_B, -1, 1'b0, "b 5/9");
    // Divide-by-zero completes on the accept edge itself
    run(0, 22'd1234, 11'd0, 1'b0, 22'h3FFFFF, 11'd0, 1'b1, 0, -1, 1'b0, "a 1234/0");
    run(0, 22'd100, 11'd7, 1'b0, 22'd14, 11'd2, 1'b0, LAT_A, -1, 1'b0, "a 100/7 after dbz");
    run(0, 22'd500, 11'd3, 1'b0, 22'd166, 11'd2, 1'b0, LAT_A, 5, 1'b0, "a stray start");
    run(1, 22'h3FFFFF, 11'h7FF, 1'b0, 22'd2049, 11'd0, 1'b0, LAT_B, -1, 1'b0, "b max/max");
    run(1, 22'h3FFFFF, 11'd1, 1'b0, 22'h3FFFFF, 11'd0, 1'b0, LAT_B, -1, 1'b0, "b max/1");

    // Abort at iteration 5 keeps the previous result (500/3)
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 22'd2000, 11'd9, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 22'd2000, 11'd9, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    drive(0, 1'b0, 1'b1, 22'd2000, 11'd9, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 22'd2000, 11'd9, 1'b0);
    chk("abort busy", 64'(ia.busy), 64'd0);
    chk("abort done", 64'(ia.done), 64'd0);
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (ia.done) seen++; end
    chk("abort no done", 64'(seen), 64'd0);
    chk("abort quotient kept", 64'(ia.quotient), 64'd166);
    chk("abort remainder kept", 64'(ia.remainder), 64'd2);
    chk("abort dbz kept", 64'(ia.dbz), 64'd0);

    // Reset at iteration 5 clears everything
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 22'd2000, 11'd9, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 22'd2000, 11'd9, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst busy", 64'(ia.busy), 64'd0);
    chk("rst done", 64'(ia.done), 64'd0);
    chk("rst quotient", 64'(ia.quotient), 64'd0);
    chk("rst remainder", 64'(ia.remainder), 64'd0);
    chk("rst b quotient", 64'(ib.quotient), 64'd0);
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (ia.done) seen++; end
    chk("rst no done", 64'(seen), 64'd0);

    run(0, 22'd50, 11'd5, 1'b0, 22'd10, 11'd0, 1'b0, LAT_A, -1, 1'b1, "a start beats abort");

    // Back-to-back random operands, start raised in the cycle after done
    for (int i = 0; i < 16; i++) begin
      ra = 22'($urandom_range(0, 22'h3FFFFF));
      rb = 11'($urandom_range(1, 11'h7FF));
      run(i % 2, ra, rb, 1'b0, ra / 22'(rb), 11'(ra % 22'(rb)), 1'b0,
          (i % 2 == 0) ? LAT_A : LAT_B, -1, 1'b0, $sformatf("rand %0d", i));
    end

`ifdef UL_DIV_SEQ_SIGNED_EN
    run(0, 22'h3FFFF9, 11'd2, 1'b1, 22'h3FFFFD, 11'h7FF, 1'b0, LAT_A, -1, 1'b0, "s -7/2");
    run(0, 22'd7, 11'h7FE, 1'b1, 22'h3FFFFD, 11'd1, 1'b0, LAT_A, -1, 1'b0, "s 7/-2");
    run(0, 22'h200000, 11'h7FF, 1'b1, 22'h200000, 11'd0, 1'b0, LAT_A, -1, 1'b0, "s min/-1");
    run(1, 22'h3FFFF9, 11'h7FE, 1'b1, 22'd3, 11'h7FF, 1'b0, LAT_B, -1, 1'b0, "s -7/-2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
